// File: rtl/itch_message_framer.sv
// Walks the little-endian 2-byte length prefixes of a 64-bit ITCH word stream and reports each header.
// Results are registered one cycle after evaluation; inReady drops while a word still holds unprocessed headers.
module itch_message_framer #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [63:0]      inData,
  output logic             inReady,
  output logic [63:0]      outData,
  output logic             msgStart,
  output logic [5:0]       msgOffset,
  output logic [15:0]      msgLength,
  output logic             msgSplit,
  output logic             lenError,
  output logic [CNT_W-1:0] msgCount
);

  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_HDR1 = 2'd1, ST_SEEK = 2'd2} state_e;

  state_e           st_q, st_d;
  logic [3:0]       pos_q, pos_d;
  logic [15:0]      rem_q, rem_d;
  logic [7:0]       lo_q, lo_d;
  logic [63:0]      data_q;
  logic             start_q, split_q, err_q;
  logic [5:0]       off_q;
  logic [15:0]      len_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]  pos_lo, pos_hi;
  logic [7:0]  byte_lo, byte_hi;
  logic [15:0] hdr_len, avail;
  logic [3:0]  pos_p2;
  logic        len_bad;
  logic        rdy, pulse, split_d;
  logic [5:0]  off_d;

  assign pos_lo  = pos_q[2:0];
  assign pos_hi  = pos_q[2:0] + 3'd1;
  assign byte_lo = inData[{pos_lo, 3'b000} +: 8];
  assign byte_hi = inData[{pos_hi, 3'b000} +: 8];
  // A split header takes its low byte from the previous word.
  assign hdr_len = (st_q == ST_HDR1) ? {inData[7:0], lo_q} : {byte_hi, byte_lo};
  assign avail   = 16'd8 - {12'd0, pos_q};
  assign pos_p2  = pos_q + 4'd2;
  assign len_bad = (hdr_len == 16'd0) || (32'(hdr_len) > MAX_LEN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q    <= ST_HDR;
      pos_q   <= 4'd0;
      rem_q   <= 16'd0;
      lo_q    <= 8'd0;
      data_q  <= 64'd0;
      start_q <= 1'b0;
      off_q   <= 6'd0;
      len_q   <= 16'd0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (inValid) begin
      st_q    <= st_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      data_q  <= inData;
      start_q <= pulse;
      err_q   <= pulse && len_bad;
      if (pulse) begin
        off_q   <= off_d;
        len_q   <= hdr_len;
        split_q <= split_d;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  always_comb begin
    st_d  = st_q;
    pos_d = pos_q;
    rem_d = rem_q;
    lo_d  = lo_q;
    if (inValid) begin
      case (st_q)
        ST_HDR: begin
          if (pos_q == 4'd7) begin
            lo_d  = byte_lo;
            pos_d = 4'd0;
            st_d  = ST_HDR1;
          end else begin
            rem_d = hdr_len;
            pos_d = (pos_p2 == 4'd8) ? 4'd0 : pos_p2;
            st_d  = (hdr_len == 16'd0) ? ST_HDR : ST_SEEK;
          end
        end
        ST_HDR1: begin
          rem_d = hdr_len;
          pos_d = 4'd1;
          st_d  = (hdr_len == 16'd0) ? ST_HDR : ST_SEEK;
        end
        ST_SEEK: begin
          if (rem_q >= avail) begin
            rem_d = rem_q - avail;
            pos_d = 4'd0;
            st_d  = (rem_q == avail) ? ST_HDR : ST_SEEK;
          end else begin
            pos_d = pos_q + rem_q[3:0];
            rem_d = 16'd0;
            st_d  = ST_HDR;
          end
        end
        default: st_d = ST_HDR;
      endcase
    end
  end

  // Readiness depends only on state so the upstream can present data freely.
  always_comb begin
    rdy     = 1'b0;
    pulse   = 1'b0;
    off_d   = 6'd0;
    split_d = 1'b0;
    case (st_q)
      ST_HDR: begin
        rdy   = (pos_q == 4'd6) || (pos_q == 4'd7);
        pulse = (pos_q != 4'd7);
        off_d = {pos_lo, 3'b000};
      end
      ST_HDR1: begin
        pulse   = 1'b1;
        off_d   = 6'd56;
        split_d = 1'b1;
      end
      ST_SEEK: rdy = (rem_q >= avail);
      default: rdy = 1'b0;
    endcase
  end

  assign inReady   = rst && rdy;
  assign outData   = data_q;
  assign msgStart  = start_q;
  assign msgOffset = off_q;
  assign msgLength = len_q;
  assign msgSplit  = split_q;
  assign lenError  = err_q;
  assign msgCount  = cnt_q;

endmodule
